prob2_tx: RTL

- Serial stimulus transmitter for the prob2 sequence detector. It is the sending end of the single-bit X line.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on X.
- Runs a cycle-exact model of the detector's 8-state Mealy machine to produce the Z1/Z2 values the detector must return for the transmitted stream.
- Sits between the test/control logic and the detector's X input; the expected outputs feed a checker.

---
 rtl/prob2_tx_if.sv | 23 ++
 rtl/prob2_tx.sv | 131 +++++++++++++
 2 files changed

// File: rtl/prob2_tx_if.sv
// Word handshake into the prob2 transmitter, plus its serial line and the
// detector outputs it predicts for that line.
interface prob2_tx_if #(parameter int WIDTH = 8) ();
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             X;
  logic             x_valid;
  logic             busy;
  logic             exp_z1;
  logic             exp_z2;
  logic [15:0]      words_sent;

  modport master (
    output data_in, data_valid,
    input  data_ready, X, x_valid, busy, exp_z1, exp_z2, words_sent
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, X, x_valid, busy, exp_z1, exp_z2, words_sent
  );
endinterface

// File: rtl/prob2_tx.sv
// Serialises words onto the prob2 detector's X line and runs a cycle-exact
// copy of the detector's Mealy machine to predict its Z1/Z2 response.
//
// state    | meaning
// ST_IDLE  | line idle, ready for a word
// ST_SHIFT | one word bit per cycle on X, cnt_q = bits left after this one
// ST_GAP   | idle-level gap after a word, cnt_q = gap cycles left after this one
module prob2_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP        = 0,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input logic      clk,
  input logic      rst,
  prob2_tx_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} tx_state_e;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} det_state_e;

  tx_state_e        state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [15:0]      words_q, words_d;
  det_state_e       det_q, det_d;
  logic             z1_q, z1_d, z2_q, z2_d;

  logic tx_bit, last, ready, accept, x_out;

  assign tx_bit = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
  assign last   = (cnt_q == 5'd0);
  // Back-to-back streaming: with no gap the next word loads on the last bit.
  assign ready  = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last && (GAP == 0));
  assign accept = bus.data_valid && ready;
  assign x_out  = (state_q == ST_SHIFT) ? tx_bit : 1'(IDLE_LEVEL);

  assign bus.data_ready = ready;
  assign bus.X          = x_out;
  assign bus.x_valid    = (state_q == ST_SHIFT);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.exp_z1     = z1_q;
  assign bus.exp_z2     = z2_q;
  assign bus.words_sent = words_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d  = bus.data_in;
          cnt_d   = 5'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
        if (last) begin
          words_d = words_q + 16'd1;
          if (GAP > 0) begin
            cnt_d   = 5'(GAP - 1);
            state_d = ST_GAP;
          end else if (accept) begin
            sreg_d = bus.data_in;
            cnt_d  = 5'(WIDTH - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_GAP: begin
        if (last) state_d = ST_IDLE;
        else      cnt_d   = cnt_q - 5'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Detector model sees the same X the detector samples, idle cycles included.
  always_comb begin
    det_d = S0;
    z1_d  = 1'b0;
    z2_d  = 1'b0;
    case (det_q)
      S0: det_d = x_out ? S3 : S1;
      S1: det_d = x_out ? S2 : S1;
      S2: begin
        det_d = x_out ? S3 : S4;
        z1_d  = !x_out;
      end
      S3: det_d = x_out ? S3 : S4;
      S4: begin
        det_d = x_out ? S3 : S5;
        z2_d  = !x_out;
      end
      S5: det_d = x_out ? S6 : S5;
      S6: det_d = x_out ? S6 : S7;
      S7: begin
        det_d = x_out ? S6 : S5;
        z2_d  = !x_out;
      end
      default: det_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      words_q <= '0;
      det_q   <= S0;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      words_q <= words_d;
      det_q   <= det_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
    end
  end

endmodule
